// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, binary index and holder run-length counter.
// Build option RR_ARB_HOLD_EN: lock mode, where the holder keeps the grant until it releases or hits MAX_HOLD.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDXW     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic [7:0]      busy_cnt
);

  // state | meaning
  // IDLE  | no requester was seen at the last edge, gnt = 0
  // GRANT | exactly one requester owns the shared line

  if (N < 2 || N > 16 || IDXW != $clog2(N) || MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      busy_q, busy_d;

  logic [IDXW-1:0] win_idx;
  logic            win_found;
  logic            keep;

  // First set request bit at or after ptr, wrapping past N-1; ptr is always < N.
  always_comb begin
    logic [IDXW-1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDXW'((int'(ptr_q) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef RR_ARB_HOLD_EN
  logic hold_req;
  logic others_req;
  logic force_rel;

  always_comb begin
    hold_req   = |(gnt_q & req);
    others_req = |(req & ~gnt_q);
    force_rel  = (MAX_HOLD != 0) && (busy_q == 8'(MAX_HOLD)) && others_req;
    keep       = (state_q == GRANT) && hold_req && !force_rel;
  end
`else
  always_comb begin
    keep = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    idx_d   = '0;
    busy_d  = '0;
    case (state_q)
      IDLE:  state_d = (|req) ? GRANT : IDLE;
      GRANT: state_d = (|req) ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
    if (|req) begin
      if (keep) begin
        gnt_d = gnt_q;
        idx_d = idx_q;
      end else begin
        gnt_d[win_idx] = 1'b1;
        idx_d          = win_idx;
        ptr_d          = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
      end
      // Run length restarts whenever ownership changes, including idle -> grant.
      if (gnt_d == gnt_q) begin
        busy_d = (busy_q == 8'hFF) ? busy_q : busy_q + 8'd1;
      end else begin
        busy_d = 8'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    gnt      = (state_q == GRANT) ? gnt_q : '0;
    gnt_idx  = (state_q == GRANT) ? idx_q : '0;
    gnt_vld  = |gnt;
    busy_cnt = busy_q;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_d));
      assert ((gnt_d & ~req) == '0);
      assert (int'(ptr_q) < N);
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=4, MAX_HOLD=8): behavioural model feeds a scoreboard queue,
// plus directed checks of the documented sequences; lock-mode checks follow RR_ARB_HOLD_EN.
module tb_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [7:0] busy_cnt;

  typedef struct {
    logic [3:0] g;
    logic [1:0] i;
    logic       v;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  int m_ptr    = 0;
  int m_holder = -1;
  int m_busy   = 0;

  rr_arbiter #(.N(N), .IDXW(2), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq);
    int  nxt;
    bit  keep;
    keep = 1'b0;
    if (r) begin
      m_ptr = 0; m_holder = -1; m_busy = 0;
    end else if (rq == 4'b0) begin
      m_holder = -1; m_busy = 0;
    end else begin
`ifdef RR_ARB_HOLD_EN
      if (m_holder >= 0 && rq[m_holder])
        keep = !(MAX_HOLD != 0 && m_busy == MAX_HOLD && (rq & ~(4'b0001 << m_holder)) != 4'b0);
`endif
      nxt = m_holder;
      if (!keep) begin
        nxt = -1;
        for (int k = N - 1; k >= 0; k--)
          if (rq[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
        m_ptr = (nxt + 1) % N;
      end
      if (nxt == m_holder) m_busy = (m_busy < 255) ? m_busy + 1 : 255;
      else m_busy = 1;
      m_holder = nxt;
    end
  endtask

  // One clock: drive at the falling edge, push expectation, compare just after the rising edge.
  task automatic cyc(input logic r, input logic [3:0] rq);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model_step(r, rq);
    e.g = (m_holder < 0) ? 4'b0 : 4'(1 << m_holder);
    e.i = (m_holder < 0) ? 2'd0 : 2'(m_holder);
    e.v = (m_holder >= 0);
    e.b = 8'(m_busy);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt", gnt, e.g);
    check("gnt_idx", gnt_idx, e.i);
    check("gnt_vld", gnt_vld, e.v);
    check("busy_cnt", busy_cnt, e.b);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;

    cyc(1'b1, 4'b1111);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_vld", gnt_vld, 1'b0);
    check("rst_idx", gnt_idx, 2'd0);
    check("rst_busy", busy_cnt, 8'd0);
    cyc(1'b0, 4'b1111);
    check("first_gnt", gnt, 4'b0001);

`ifndef RR_ARB_HOLD_EN
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 4'b1111);
      check("rot_idx", gnt_idx, 32'(i % 4));
      check("rot_gnt", gnt, 32'(1 << (i % 4)));
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'b1001);
      check("sparse_gnt", gnt, (i % 2 == 0) ? 32'h1 : 32'h8);
    end
    cyc(1'b0, 4'b0000);
    check("idle_gnt", gnt, 4'b0000);
    check("idle_vld", gnt_vld, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 4'b0100);
      check("lone_busy", busy_cnt, 32'(i));
    end
    cyc(1'b0, 4'b1000);
    check("handoff_gnt", gnt, 4'b1000);
    check("handoff_busy", busy_cnt, 8'd1);
`else
    cyc(1'b1, 4'b0000);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 4'b0010);
      check("lock_busy", busy_cnt, 32'(i));
    end
    for (int i = 4; i <= 8; i++) begin
      cyc(1'b0, 4'b0110);
      check("lock_hold", gnt, 4'b0010);
      check("lock_busy", busy_cnt, 32'(i));
    end
    cyc(1'b0, 4'b0110);
    check("force_gnt", gnt, 4'b0100);
    check("force_busy", busy_cnt, 8'd1);
    cyc(1'b0, 4'b1000);
    check("handoff_gnt", gnt, 4'b1000);
    for (int i = 0; i < 12; i++) cyc(1'b0, 4'b0001);
    check("lone_hold", gnt, 4'b0001);
    check("lone_busy", busy_cnt, 8'd12);
`endif

    cyc(1'b0, 4'b0100);
    check("pre_rst_gnt", gnt, 4'b0100);
    cyc(1'b1, 4'b1111);
    check("mid_rst_gnt", gnt, 4'b0000);
    cyc(1'b0, 4'b1111);
    check("post_rst_gnt", gnt, 4'b0001);

    for (int i = 0; i < 260; i++) cyc(1'b0, 4'b0010);
    check("sat_busy", busy_cnt, 8'd255);

    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter for N requesters whose request lines are OR-merged onto one shared resource.
- Performs the return path of that merge: decides which requester owns the shared line and returns a registered one-hot grant plus a binary index.
- Used wherever several gate-level sources drive one OR'd bus or event line and exactly one owner is needed per cycle.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IDXW, 2, width of gnt_idx; must equal ceil(log2(N)).
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant while another requester waits; 0 = unlimited. Used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector; bit i = requester i wants the resource.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_idx  output  IDXW  binary index of the granted bit; 0 when idle.
- gnt_vld  output  1  OR-reduction of gnt.
- busy_cnt  output  8  count of consecutive cycles the current holder has been granted; saturates at 255.

Behaviour:
- Reset (rst=1 at a clk edge): gnt=0, gnt_idx=0, gnt_vld=0, busy_cnt=0, internal priority pointer ptr=0. Reset overrides all other activity, including mid-grant; the grant drops at that same edge.
- Latency: grant is registered. req sampled at edge k produces gnt valid after edge k; there is no combinational req->gnt path.
- Arbitration: search req starting at bit ptr, ascending with wrap (N-1 -> 0). The first set bit wins.
- On granting bit i: ptr <= (i+1) mod N.
- No req bit set: gnt=0, gnt_vld=0, gnt_idx=0, busy_cnt=0; ptr unchanged.
- gnt is always one-hot or zero. A bit is granted only if its req was 1 at the sampling edge.
- gnt_idx is consistent with gnt in the same cycle. gnt_vld = |gnt.
- busy_cnt:
  - resets to 1 on a new grant or a change of holder;
  - increments while the same holder is re-granted on consecutive cycles;
  - saturates at 255.
- Default mode (feature off): re-arbitrate every cycle.
  - A lone continuous requester is granted every cycle and busy_cnt increments.
  - With several requesters active, the grant rotates each cycle in index order.
- State machine, 2 states:
  - IDLE (gnt=0): any req -> GRANT.
  - GRANT: no req -> IDLE; otherwise stay in GRANT, and the holder is chosen per the mode rules.
- Boundary conditions:
  - Holder drops req while others are pending: next holder is granted at the same edge, with no idle cycle.
  - All req bits set: strict rotation 0,1,...,N-1,0 regardless of start.
  - ptr wraps from N-1 to 0.
  - req bits at or above N do not exist; no X propagation from unused pointer codes (ptr is always < N).

Optional Feature:
- Macro: RR_ARB_HOLD_EN.
- When defined (lock mode):
  - The current holder keeps the grant while its req stays 1 and ptr does not advance past it.
  - Release occurs when the holder's req is sampled 0. Re-arbitration then happens at that edge, searching from (holder+1) mod N.
  - If MAX_HOLD != 0 and busy_cnt == MAX_HOLD and some other req bit is 1, the holder is forcibly released at the next edge and the next requester is granted.
  - A lone holder is never forced off.
- When not defined: per-cycle rotation as described above; MAX_HOLD is ignored.

Test Plan (N=4, MAX_HOLD=8):
- Reset: rst=1 with req=4'b1111 -> after the edge gnt=0, gnt_vld=0, gnt_idx=0, busy_cnt=0; after rst is released, the first grant is gnt=4'b0001 one cycle later.
- Rotation (feature off): req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... with gnt_idx 0,1,2,3,0.
- Sparse and wrap: req=4'b1001 starting at ptr=0 -> gnt 0001,1000,0001,1000; then req=0 -> gnt=0 and gnt_vld=0 after one edge.
- Lock (RR_ARB_HOLD_EN): req=4'b0010 for 3 cycles, then req=4'b0110 -> gnt stays 0010; busy_cnt counts 1..8; at the edge after busy_cnt=8, gnt=0100 and busy_cnt=1.
- Handoff (RR_ARB_HOLD_EN): holder bit 2, req goes 0100->1000 at edge k -> gnt=1000 after edge k, with no idle cycle.
- Mid-grant reset: gnt=0100 with rst pulsed for 1 cycle -> gnt=0 after that edge; with req=1111, the next grant is 0001 (ptr restored to 0).
